// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the clock time-setting controller: state encoding,
// digit widths, wrap constants and next-hour/next-minute helpers.
package time_set_ctrl_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned HR_TENS_W  = 2;
    localparam int unsigned HR_ONES_W  = 4;
    localparam int unsigned MIN_TENS_W = 3;
    localparam int unsigned MIN_ONES_W = 4;

    localparam int unsigned MIN_TENS_TC = 5;
    localparam int unsigned ONES_TC     = 9;
    localparam int unsigned HR_WRAP     = 23;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } tsc_state_e;

    typedef struct packed {
        logic [HR_TENS_W-1:0] tens;
        logic [HR_ONES_W-1:0] ones;
    } hr_digits_t;

    typedef struct packed {
        logic [MIN_TENS_W-1:0] tens;
        logic [MIN_ONES_W-1:0] ones;
    } min_digits_t;

    // 23 and any out-of-range hour both wrap to 00
    function automatic hr_digits_t next_hour(input hr_digits_t cur);
        hr_digits_t  nxt;
        int unsigned value;
        nxt   = '0;
        value = 32'(cur.tens) * 32'd10 + 32'(cur.ones);
        if ((cur.ones <= HR_ONES_W'(ONES_TC)) && (value < HR_WRAP)) begin
            if (cur.ones == HR_ONES_W'(ONES_TC)) begin
                nxt.tens = cur.tens + HR_TENS_W'(1);
            end else begin
                nxt.tens = cur.tens;
                nxt.ones = cur.ones + HR_ONES_W'(1);
            end
        end
        return nxt;
    endfunction

    // 59 and any out-of-range minute both wrap to 00
    function automatic min_digits_t next_minute(input min_digits_t cur);
        min_digits_t nxt;
        logic        at_top;
        nxt    = '0;
        at_top = (cur.tens == MIN_TENS_W'(MIN_TENS_TC)) && (cur.ones == MIN_ONES_W'(ONES_TC));
        if ((cur.ones <= MIN_ONES_W'(ONES_TC)) && (cur.tens <= MIN_TENS_W'(MIN_TENS_TC)) && !at_top) begin
            if (cur.ones == MIN_ONES_W'(ONES_TC)) begin
                nxt.tens = cur.tens + MIN_TENS_W'(1);
            end else begin
                nxt.tens = cur.tens;
                nxt.ones = cur.ones + MIN_ONES_W'(1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/time_set_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, tick-based debouncer and a
// one-clk press event on each accepted 0->1 transition.
module tsc_debounce #(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic clk_i,
    input  logic nRst_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Counter only survives while the synced level disagrees with the stable one
    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q1 <= btn_i;
            sync_q2 <= sync_q1;
            press_q <= 1'b0;
            if (sync_q2 == stable_q) begin
                cnt_q <= '0;
            end else if (tick_i) begin
                if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
                    stable_q <= sync_q2;
                    press_q  <= sync_q2;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode/inc buttons walk RUN -> SET_HR -> SET_MIN and
// issue load strobes to the counter stages. Optional auto-repeat on a held inc
// button is enabled by defining TIME_SET_CTRL_AUTOREPEAT_EN.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 200
) (
    input  logic                  clk_i,
    input  logic                  nRst_i,
    input  logic                  tick_1khz_i,
    input  logic                  mode_btn_i,
    input  logic                  inc_btn_i,
    input  logic [HR_TENS_W-1:0]  hr_tens_i,
    input  logic [HR_ONES_W-1:0]  hr_ones_i,
    input  logic [MIN_TENS_W-1:0] min_tens_i,
    input  logic [MIN_ONES_W-1:0] min_ones_i,
    output logic                  nLoadHr_o,
    output logic                  nLoadMin_o,
    output logic                  nLoadSec_o,
    output logic [HR_TENS_W-1:0]  hr_tens_ld_o,
    output logic [HR_ONES_W-1:0]  hr_ones_ld_o,
    output logic [MIN_TENS_W-1:0] min_tens_ld_o,
    output logic [MIN_ONES_W-1:0] min_ones_ld_o,
    output logic                  run_en_o,
    output logic [STATE_W-1:0]    state_o
);

    logic mode_ev;
    logic mode_level;
    logic inc_press;
    logic inc_level;
    logic inc_ev;
    logic unused_cfg;

    tsc_state_e  state_q, state_d;
    logic        nld_hr_q, nld_hr_d;
    logic        nld_min_q, nld_min_d;
    logic        nld_sec_q, nld_sec_d;
    logic        run_en_q;
    hr_digits_t  hr_ld_q, hr_ld_d;
    min_digits_t min_ld_q, min_ld_d;
    hr_digits_t  hr_cur;
    min_digits_t min_cur;

    tsc_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode_db (
        .clk_i   (clk_i),
        .nRst_i  (nRst_i),
        .tick_i  (tick_1khz_i),
        .btn_i   (mode_btn_i),
        .level_o (mode_level),
        .press_o (mode_ev)
    );

    tsc_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_inc_db (
        .clk_i   (clk_i),
        .nRst_i  (nRst_i),
        .tick_i  (tick_1khz_i),
        .btn_i   (inc_btn_i),
        .level_o (inc_level),
        .press_o (inc_press)
    );

`ifdef TIME_SET_CTRL_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int unsigned REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_armed_q;
    logic             rep_ev_q;
    logic             setting;

    assign setting = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);

    // Counts ticks since acceptance; first repeat after the delay, then at the rate
    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_ev_q    <= 1'b0;
        end else begin
            rep_ev_q <= 1'b0;
            if (!inc_level || !setting || mode_ev) begin
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b0;
            end else if (tick_1khz_i) begin
                if (!rep_armed_q && (rep_cnt_q == REP_W'(REPEAT_DELAY_MS - 1))) begin
                    rep_ev_q    <= 1'b1;
                    rep_armed_q <= 1'b1;
                    rep_cnt_q   <= '0;
                end else if (rep_armed_q && (rep_cnt_q == REP_W'(REPEAT_RATE_MS - 1))) begin
                    rep_ev_q  <= 1'b1;
                    rep_cnt_q <= '0;
                end else begin
                    rep_cnt_q <= rep_cnt_q + REP_W'(1);
                end
            end
        end
    end

    assign inc_ev     = inc_press | rep_ev_q;
    assign unused_cfg = mode_level;
`else
    assign inc_ev     = inc_press;
    assign unused_cfg = ^{mode_level, inc_level, REPEAT_DELAY_MS, REPEAT_RATE_MS};
`endif

    assign hr_cur  = '{tens: hr_tens_i, ones: hr_ones_i};
    assign min_cur = '{tens: min_tens_i, ones: min_ones_i};

    // Next state and load strobes; mode has priority over inc in the same clk
    always_comb begin
        state_d   = state_q;
        nld_hr_d  = 1'b1;
        nld_min_d = 1'b1;
        nld_sec_d = 1'b1;
        hr_ld_d   = hr_ld_q;
        min_ld_d  = min_ld_q;
        case (state_q)
            ST_RUN: begin
                if (mode_ev) state_d = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (mode_ev) begin
                    state_d = ST_SET_MIN;
                end else if (inc_ev) begin
                    nld_hr_d = 1'b0;
                    hr_ld_d  = next_hour(hr_cur);
                end
            end
            ST_SET_MIN: begin
                if (mode_ev) begin
                    state_d   = ST_RUN;
                    nld_sec_d = 1'b0;
                end else if (inc_ev) begin
                    nld_min_d = 1'b0;
                    min_ld_d  = next_minute(min_cur);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q   <= ST_RUN;
            run_en_q  <= 1'b1;
            nld_hr_q  <= 1'b1;
            nld_min_q <= 1'b1;
            nld_sec_q <= 1'b1;
            hr_ld_q   <= '0;
            min_ld_q  <= '0;
        end else begin
            state_q   <= state_d;
            run_en_q  <= (state_d == ST_RUN);
            nld_hr_q  <= nld_hr_d;
            nld_min_q <= nld_min_d;
            nld_sec_q <= nld_sec_d;
            hr_ld_q   <= hr_ld_d;
            min_ld_q  <= min_ld_d;
        end
    end

    assign nLoadHr_o     = nld_hr_q;
    assign nLoadMin_o    = nld_min_q;
    assign nLoadSec_o    = nld_sec_q;
    assign hr_tens_ld_o  = hr_ld_q.tens;
    assign hr_ones_ld_o  = hr_ld_q.ones;
    assign min_tens_ld_o = min_ld_q.tens;
    assign min_ones_ld_o = min_ld_q.ones;
    assign run_en_o      = run_en_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed button sequences with random
// bounce and random digit inputs, checked against an arithmetic time model.
module tb_time_set_ctrl;

    localparam int TICK_DIV = 5;
    localparam int DEB      = 20;

    logic       clk = 1'b0;
    logic       nRst_i = 1'b0;
    logic       tick = 1'b0;
    int         tick_div = 0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [1:0] hr_tens_i = '0;
    logic [3:0] hr_ones_i = '0;
    logic [2:0] min_tens_i = '0;
    logic [3:0] min_ones_i = '0;
    logic       nLoadHr_o, nLoadMin_o, nLoadSec_o, run_en_o;
    logic [1:0] hr_tens_ld_o;
    logic [3:0] hr_ones_ld_o;
    logic [2:0] min_tens_ld_o;
    logic [3:0] min_ones_ld_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int hr_lows = 0, min_lows = 0, sec_lows = 0, multi_low = 0;

    time_set_ctrl u_dut (
        .clk_i         (clk),
        .nRst_i        (nRst_i),
        .tick_1khz_i   (tick),
        .mode_btn_i    (mode_btn),
        .inc_btn_i     (inc_btn),
        .hr_tens_i     (hr_tens_i),
        .hr_ones_i     (hr_ones_i),
        .min_tens_i    (min_tens_i),
        .min_ones_i    (min_ones_i),
        .nLoadHr_o     (nLoadHr_o),
        .nLoadMin_o    (nLoadMin_o),
        .nLoadSec_o    (nLoadSec_o),
        .hr_tens_ld_o  (hr_tens_ld_o),
        .hr_ones_ld_o  (hr_ones_ld_o),
        .min_tens_ld_o (min_tens_ld_o),
        .min_ones_ld_o (min_ones_ld_o),
        .run_en_o      (run_en_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
        tick     <= (tick_div == TICK_DIV - 1);
    end

    // Strobe observer: counts low cycles of each load strobe and overlaps
    always @(negedge clk) begin
        if (!nLoadHr_o)  hr_lows  <= hr_lows + 1;
        if (!nLoadMin_o) min_lows <= min_lows + 1;
        if (!nLoadSec_o) sec_lows <= sec_lows + 1;
        if ((32'(!nLoadHr_o) + 32'(!nLoadMin_o) + 32'(!nLoadSec_o)) > 1) multi_low <= multi_low + 1;
    end

    function automatic int model_next_hr(input int t, input int o);
        int h;
        if (o > 9) return 0;
        h = t * 10 + o;
        if (h >= 23) return 0;
        return h + 1;
    endfunction

    function automatic int model_next_min(input int t, input int o);
        int m;
        if (o > 9 || t > 5) return 0;
        m = t * 10 + o;
        return (m == 59) ? 0 : m + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int sel, input logic v);
        if (sel == 0 || sel == 2) mode_btn = v;
        if (sel == 1 || sel == 2) inc_btn = v;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TICK_DIV) @(negedge clk);
    endtask

    task automatic bounce(input int sel, input int ticks);
        int k;
        int step;
        k = 0;
        while (k < ticks * TICK_DIV) begin
            step = int'($urandom_range(1, 3));
            set_btn(sel, 1'($urandom_range(0, 1)));
            repeat (step) @(negedge clk);
            k += step;
        end
    endtask

    task automatic press(input int sel, input int bounce_ticks, input int hold_ticks);
        bounce(sel, bounce_ticks);
        set_btn(sel, 1'b1);
        wait_ticks(hold_ticks);
        bounce(sel, 5);
        set_btn(sel, 1'b0);
        wait_ticks(DEB + 5);
    endtask

    initial begin : main
        int s_hr, s_min, s_sec;
        int t, o, e, last_hr, loads;
        bit seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_o), 0);
        check("rst_run_en", 32'(run_en_o), 1);
        check("rst_nloads", 32'({nLoadHr_o, nLoadMin_o, nLoadSec_o}), 7);
        check("rst_ld", 32'({hr_tens_ld_o, hr_ones_ld_o, min_tens_ld_o, min_ones_ld_o}), 0);
        nRst_i = 1'b1;
        wait_ticks(5);

        // Inc in RUN is ignored
        s_hr = hr_lows; s_min = min_lows; s_sec = sec_lows;
        press(1, 10, 30);
        check("run_inc_loads", 32'((hr_lows - s_hr) + (min_lows - s_min) + (sec_lows - s_sec)), 0);
        check("run_inc_state", 32'(state_o), 0);

        // Bounced mode press -> exactly one event
        press(0, 10, 25);
        check("mode1_state", 32'(state_o), 1);
        check("mode1_run_en", 32'(run_en_o), 0);

        // Hour wrap 23 -> 00 and carry 19 -> 20
        hr_tens_i = 2; hr_ones_i = 3;
        s_hr = hr_lows; s_min = min_lows; s_sec = sec_lows;
        press(1, 10, 30);
        check("hr23_strobe_cycles", 32'(hr_lows - s_hr), 1);
        check("hr23_other_strobes", 32'((min_lows - s_min) + (sec_lows - s_sec)), 0);
        check("hr23_ld", 32'({hr_tens_ld_o, hr_ones_ld_o}), 0);
        hr_tens_i = 1; hr_ones_i = 9;
        press(1, 10, 30);
        check("hr19_tens", 32'(hr_tens_ld_o), 2);
        check("hr19_ones", 32'(hr_ones_ld_o), 0);

        // Random hours, including out-of-range ones digits
        last_hr = 20;
        for (int i = 0; i < 6; i++) begin
            t = int'($urandom_range(0, 3));
            o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            hr_tens_i = 2'(t); hr_ones_i = 4'(o);
            s_hr = hr_lows;
            press(1, 5, 30);
            e = model_next_hr(t, o);
            last_hr = e;
            check("hr_rand_strobe", 32'(hr_lows - s_hr), 1);
            check("hr_rand_tens", 32'(hr_tens_ld_o), 32'(e / 10));
            check("hr_rand_ones", 32'(hr_ones_ld_o), 32'(e % 10));
        end

        press(0, 10, 30);
        check("mode2_state", 32'(state_o), 2);

        // Minute wrap 59 -> 00
        min_tens_i = 5; min_ones_i = 9;
        s_min = min_lows;
        press(1, 10, 30);
        check("min59_strobe", 32'(min_lows - s_min), 1);
        check("min59_ld", 32'({min_tens_ld_o, min_ones_ld_o}), 0);

        for (int i = 0; i < 6; i++) begin
            t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            min_tens_i = 3'(t); min_ones_i = 4'(o);
            s_min = min_lows;
            press(1, 5, 30);
            e = model_next_min(t, o);
            check("min_rand_strobe", 32'(min_lows - s_min), 1);
            check("min_rand_tens", 32'(min_tens_ld_o), 32'(e / 10));
            check("min_rand_ones", 32'(min_ones_ld_o), 32'(e % 10));
        end
        check("hr_ld_held", 32'(hr_tens_ld_o) * 10 + 32'(hr_ones_ld_o), 32'(last_hr));

        // SET_MIN -> RUN zeroes seconds
        s_hr = hr_lows; s_min = min_lows; s_sec = sec_lows;
        press(0, 10, 30);
        check("exit_sec_strobe", 32'(sec_lows - s_sec), 1);
        check("exit_no_hr_min", 32'((hr_lows - s_hr) + (min_lows - s_min)), 0);
        check("exit_state", 32'(state_o), 0);
        check("exit_run_en", 32'(run_en_o), 1);

        // Simultaneous mode+inc in SET_HR: mode wins
        press(0, 10, 30);
        check("enter_hr_state", 32'(state_o), 1);
        s_hr = hr_lows; s_min = min_lows;
        press(2, 10, 30);
        check("both_state", 32'(state_o), 2);
        check("both_no_hr", 32'(hr_lows - s_hr), 0);
        check("both_no_min", 32'(min_lows - s_min), 0);

        // Long inc hold in SET_MIN from 00
        min_tens_i = 0; min_ones_i = 0;
        s_min = min_lows;
        press(1, 10, 1100);
        loads = min_lows - s_min;
`ifdef TIME_SET_CTRL_AUTOREPEAT_EN
        check("hold_loads_4or5", 32'(loads == 4 || loads == 5), 1);
`else
        check("hold_loads", 32'(loads), 1);
`endif
        check("hold_ld", 32'({min_tens_ld_o, min_ones_ld_o}), 32'({3'd0, 4'd1}));

        // Reset during a low nLoadMin_o
        min_tens_i = 3; min_ones_i = 4;
        inc_btn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < (DEB + 10) * TICK_DIV && !seen; k++) begin
            @(negedge clk);
            if (!nLoadMin_o) seen = 1'b1;
        end
        check("midstrobe_seen", 32'(seen), 1);
        #1 nRst_i = 1'b0;
        #1;
        check("midrst_nloadmin", 32'(nLoadMin_o), 1);
        check("midrst_nloads", 32'({nLoadHr_o, nLoadMin_o, nLoadSec_o}), 7);
        check("midrst_state", 32'(state_o), 0);
        check("midrst_run_en", 32'(run_en_o), 1);
        check("midrst_ld", 32'({hr_tens_ld_o, hr_ones_ld_o, min_tens_ld_o, min_ones_ld_o}), 0);
        inc_btn = 1'b0;
        repeat (4) @(negedge clk);
        nRst_i = 1'b1;
        s_hr = hr_lows; s_min = min_lows; s_sec = sec_lows;
        wait_ticks(DEB + 10);
        check("post_rst_state", 32'(state_o), 0);
        check("post_rst_strobes", 32'((hr_lows - s_hr) + (min_lows - s_min) + (sec_lows - s_sec)), 0);

        check("one_strobe_max", 32'(multi_low), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20; 1 kHz ticks a raw button must hold a new level before it is accepted.
REQ-002 SHALL have parameter REPEAT_DELAY_MS, default 500; ticks of continuous INC hold before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_RATE_MS, default 200; ticks between subsequent auto-repeats.
REQ-004 SHALL have ports: clk_i in 1, system clock; nRst_i in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: tick_1khz_i in 1, one-clk-wide 1 kHz strobe; mode_btn_i in 1, raw async active-high; inc_btn_i in 1, raw async active-high.
REQ-006 SHALL have ports: hr_tens_i in 2, hr_ones_i in 4, min_tens_i in 3, min_ones_i in 4; current digit counts from the counter stages.
REQ-007 SHALL have ports: nLoadHr_o out 1, nLoadMin_o out 1, nLoadSec_o out 1; active-low one-cycle load strobes to the counter stages.
REQ-008 SHALL have ports: hr_tens_ld_o out 2, hr_ones_ld_o out 4, min_tens_ld_o out 3, min_ones_ld_o out 4; load values.
REQ-009 SHALL have ports: run_en_o out 1, high while timekeeping runs; state_o out 2, current FSM state for display blinking.

Function
REQ-010 SHALL pass each button through a 2-FF synchronizer, then a debouncer: the counter advances on tick_1khz_i while the synced level differs from the stable level, clears when they match, and updates the stable level on reaching DEBOUNCE_MS.
REQ-011 SHALL emit a one-clk press event on each 0->1 stable transition; release produces no event.
REQ-012 SHALL implement FSM RUN(0) -> SET_HR(1) -> SET_MIN(2) -> RUN on each mode press; state 3 is illegal and SHALL recover to RUN on the next clk.
REQ-013 SHALL drive run_en_o = 1 only in RUN; state_o SHALL equal the state register.
REQ-014 SHALL ignore inc events in RUN.
REQ-015 On an inc event in SET_HR, SHALL load the next hour (23 -> 00; ones 9 -> 0 with tens+1; otherwise ones+1) from the current *_i digits, with nLoadHr_o low exactly one clk, starting the clk after the event (registered, latency 1).
REQ-016 On an inc event in SET_MIN, SHALL load the next minute (59 -> 00; ones 9 -> 0 with tens+1) with nLoadMin_o low exactly one clk, latency 1.
REQ-017 On the SET_MIN -> RUN transition, SHALL pulse nLoadSec_o low one clk, in the clk after the event, to zero the seconds stages.
REQ-018 Load value outputs SHALL hold the last computed values between strobes; seconds are always loaded with 0 externally.
REQ-019 Mode and inc events in the same clk: mode SHALL win; inc SHALL be dropped.
REQ-020 Out-of-range *_i inputs (e.g. hr 25) SHALL load 00.
REQ-021 At most one nLoad*_o SHALL be low in any clk.

Reset
REQ-022 nRst_i low SHALL asynchronously force: state RUN, run_en_o 1, all nLoad*_o 1, all *_ld_o 0, synchronizers/stable levels 0, debounce/repeat counters 0.
REQ-023 Reset asserted mid-strobe SHALL immediately return the strobe high; release SHALL take effect on the first clk edge after deassertion, with no spurious press event.

Configuration
REQ-024 With macro TIME_SET_CTRL_AUTOREPEAT_EN defined, a stable inc held in SET_HR/SET_MIN SHALL produce a repeat inc event after REPEAT_DELAY_MS ticks, then every REPEAT_RATE_MS ticks, until release or a state change.
REQ-025 Without TIME_SET_CTRL_AUTOREPEAT_EN, the repeat logic SHALL be absent; one press yields one increment.

Structure
REQ-026 Shared package SHALL hold: the state encoding (RUN/SET_HR/SET_MIN), digit widths, and wrap constants (MIN_TENS_TC 5, ONES_TC 9, HR_WRAP 23).
REQ-027 Sub-module tsc_debounce (synchronizer + debouncer + edge event) SHALL be instanced once per button.

Verification
REQ-028 Bounce mode_btn_i for 10 ms, then hold 25 ms -> exactly one mode event; state_o 0 -> 1; run_en_o falls.
REQ-029 SET_HR, inputs 23:xx, one inc press -> nLoadHr_o low 1 clk; hr_tens_ld_o 0, hr_ones_ld_o 0; the same with 19 -> 2/0.
REQ-030 SET_MIN, inputs 59, inc -> min ld 0/0; then mode -> nLoadSec_o low 1 clk, state_o 0, run_en_o 1.
REQ-031 RUN, inc press -> no strobe; mode and inc events in the same clk in SET_HR -> state SET_MIN, no nLoadHr_o.
REQ-032 With the macro defined, hold inc 1100 ms in SET_MIN from 00 -> 1 press + 3 repeats (t = 500, 700, 900 ms after acceptance; the next repeat at 1100 ms may land on the boundary) = 4 or 5 loads; without the macro -> exactly 1.
REQ-033 Assert nRst_i during a low nLoadMin_o -> strobe high within the same clk; all outputs at reset values.
